// File: rtl/triangle_animator.sv
// Rigid triangle animator: moves three vertices once per FRAMES_PER_STEP frames and bounces off the screen edges.
// Define VERTICAL_BOUNCE_EN to add an independent vertical bounce; without it the y coordinates stay at their reset values.
module triangle_animator #(
    parameter int AX0             = 320,
    parameter int AY0             = 60,
    parameter int BX0             = 112,
    parameter int BY0             = 420,
    parameter int CX0             = 528,
    parameter int CY0             = 420,
    parameter int X_MAX           = 639,
    parameter int Y_MAX           = 479,
    parameter int STEP            = 1,
    parameter int FRAMES_PER_STEP = 1
) (
    input  logic       clk_pix,
    input  logic       resetn,
    input  logic       frame_start,
    input  logic       enable,
    output logic [9:0] ax,
    output logic [9:0] ay,
    output logic [9:0] bx,
    output logic [9:0] by,
    output logic [9:0] cx,
    output logic [9:0] cy,
    output logic       moving_right,
    output logic       moving_down,
    output logic       step_pulse
);

    localparam bit CFG_OK =
        (AX0 >= 0) && (AX0 <= X_MAX) && (BX0 >= 0) && (BX0 <= X_MAX) && (CX0 >= 0) && (CX0 <= X_MAX) &&
        (AY0 >= 0) && (AY0 <= Y_MAX) && (BY0 >= 0) && (BY0 <= Y_MAX) && (CY0 >= 0) && (CY0 <= Y_MAX) &&
        (X_MAX < 1024) && (Y_MAX < 1024) && (STEP >= 1) && (STEP <= 63) &&
        (FRAMES_PER_STEP >= 1) && (FRAMES_PER_STEP <= 255);

    if (!CFG_OK) begin : g_cfg_error
        $error("triangle_animator: parameter out of range");
    end

    typedef enum logic {DIR_NEG = 1'b0, DIR_POS = 1'b1} dir_e;

    localparam logic [10:0] X_LIM     = 11'(X_MAX);
    localparam logic [10:0] STEP_W    = 11'(STEP);
    localparam logic [7:0]  FCNT_LAST = 8'(FRAMES_PER_STEP - 1);

    function automatic logic [10:0] min3(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
        logic [9:0] m;
        m = (a < b) ? a : b;
        m = (c < m) ? c : m;
        return {1'b0, m};
    endfunction

    function automatic logic [10:0] max3(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
        logic [9:0] m;
        m = (a > b) ? a : b;
        m = (c > m) ? c : m;
        return {1'b0, m};
    endfunction

    // The clamped delta keeps every result inside 0..limit, so truncation to 10 bits is lossless.
    function automatic logic [9:0] shift(input logic [9:0] v, input logic up, input logic [10:0] amt);
        return up ? 10'({1'b0, v} + amt) : 10'({1'b0, v} - amt);
    endfunction

    logic [7:0]  fcnt_q;
    logic        step_pulse_q;
    logic        take_step;
    dir_e        h_dir_q, h_dir_d;
    logic [9:0]  ax_q, bx_q, cx_q;
    logic [9:0]  ax_d, bx_d, cx_d;
    logic [10:0] min_x, max_x, dx_amt;

    always_comb begin
        take_step = frame_start && enable && (fcnt_q == FCNT_LAST);
        min_x     = min3(ax_q, bx_q, cx_q);
        max_x     = max3(ax_q, bx_q, cx_q);
        h_dir_d   = h_dir_q;
        dx_amt    = STEP_W;
        if (h_dir_q == DIR_POS) begin
            if (max_x + STEP_W >= X_LIM) begin
                dx_amt  = X_LIM - max_x;
                h_dir_d = DIR_NEG;
            end
        end else if (min_x <= STEP_W) begin
            dx_amt  = min_x;
            h_dir_d = DIR_POS;
        end
        ax_d = shift(ax_q, h_dir_q == DIR_POS, dx_amt);
        bx_d = shift(bx_q, h_dir_q == DIR_POS, dx_amt);
        cx_d = shift(cx_q, h_dir_q == DIR_POS, dx_amt);
    end

    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            fcnt_q       <= '0;
            step_pulse_q <= 1'b0;
            h_dir_q      <= DIR_POS;
            ax_q         <= 10'(AX0);
            bx_q         <= 10'(BX0);
            cx_q         <= 10'(CX0);
        end else begin
            step_pulse_q <= take_step;
            if (frame_start && enable) begin
                fcnt_q <= take_step ? 8'd0 : fcnt_q + 8'd1;
            end
            if (take_step) begin
                h_dir_q <= h_dir_d;
                ax_q    <= ax_d;
                bx_q    <= bx_d;
                cx_q    <= cx_d;
            end
        end
    end

    assign ax           = ax_q;
    assign bx           = bx_q;
    assign cx           = cx_q;
    assign moving_right = (h_dir_q == DIR_POS);
    assign step_pulse   = step_pulse_q;

`ifdef VERTICAL_BOUNCE_EN
    localparam logic [10:0] Y_LIM = 11'(Y_MAX);

    dir_e        v_dir_q, v_dir_d;
    logic [9:0]  ay_q, by_q, cy_q;
    logic [9:0]  ay_d, by_d, cy_d;
    logic [10:0] min_y, max_y, dy_amt;

    always_comb begin
        min_y   = min3(ay_q, by_q, cy_q);
        max_y   = max3(ay_q, by_q, cy_q);
        v_dir_d = v_dir_q;
        dy_amt  = STEP_W;
        if (v_dir_q == DIR_POS) begin
            if (max_y + STEP_W >= Y_LIM) begin
                dy_amt  = Y_LIM - max_y;
                v_dir_d = DIR_NEG;
            end
        end else if (min_y <= STEP_W) begin
            dy_amt  = min_y;
            v_dir_d = DIR_POS;
        end
        ay_d = shift(ay_q, v_dir_q == DIR_POS, dy_amt);
        by_d = shift(by_q, v_dir_q == DIR_POS, dy_amt);
        cy_d = shift(cy_q, v_dir_q == DIR_POS, dy_amt);
    end

    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            v_dir_q <= DIR_POS;
            ay_q    <= 10'(AY0);
            by_q    <= 10'(BY0);
            cy_q    <= 10'(CY0);
        end else if (take_step) begin
            v_dir_q <= v_dir_d;
            ay_q    <= ay_d;
            by_q    <= by_d;
            cy_q    <= cy_d;
        end
    end

    assign ay          = ay_q;
    assign by          = by_q;
    assign cy          = cy_q;
    assign moving_down = (v_dir_q == DIR_POS);
`else
    assign ay          = 10'(AY0);
    assign by          = 10'(BY0);
    assign cy          = 10'(CY0);
    assign moving_down = 1'b0;
`endif

endmodule

// File: tb/tb_triangle_animator.sv
// Directed bench for triangle_animator: default, STEP=4 and FRAMES_PER_STEP=3 instances share one clock.
module tb_triangle_animator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef VERTICAL_BOUNCE_EN
    localparam bit VERT = 1'b1;
`else
    localparam bit VERT = 1'b0;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    logic       rst_d, rst_s, rst_f;
    logic       fs_d, fs_s, fs_f;
    logic       en;

    logic [9:0] d_ax, d_ay, d_bx, d_by, d_cx, d_cy;
    logic       d_mr, d_md, d_sp;
    logic [9:0] s_ax, s_ay, s_bx, s_by, s_cx, s_cy;
    logic       s_mr, s_md, s_sp;
    logic [9:0] f_ax, f_ay, f_bx, f_by, f_cx, f_cy;
    logic       f_mr, f_md, f_sp;

    triangle_animator u_def (
        .clk_pix(clk), .resetn(rst_d), .frame_start(fs_d), .enable(en),
        .ax(d_ax), .ay(d_ay), .bx(d_bx), .by(d_by), .cx(d_cx), .cy(d_cy),
        .moving_right(d_mr), .moving_down(d_md), .step_pulse(d_sp)
    );

    triangle_animator #(.STEP(4)) u_s4 (
        .clk_pix(clk), .resetn(rst_s), .frame_start(fs_s), .enable(en),
        .ax(s_ax), .ay(s_ay), .bx(s_bx), .by(s_by), .cx(s_cx), .cy(s_cy),
        .moving_right(s_mr), .moving_down(s_md), .step_pulse(s_sp)
    );

    triangle_animator #(.FRAMES_PER_STEP(3)) u_f3 (
        .clk_pix(clk), .resetn(rst_f), .frame_start(fs_f), .enable(en),
        .ax(f_ax), .ay(f_ay), .bx(f_bx), .by(f_by), .cx(f_cx), .cy(f_cy),
        .moving_right(f_mr), .moving_down(f_md), .step_pulse(f_sp)
    );

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // sel bit 0 = default, 1 = STEP=4, 2 = FRAMES_PER_STEP=3; returns at the negedge after the stepping edge.
    task automatic frames(input int n, input logic [2:0] sel);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            fs_d = sel[0];
            fs_s = sel[1];
            fs_f = sel[2];
            @(negedge clk);
            fs_d = 1'b0;
            fs_s = 1'b0;
            fs_f = 1'b0;
        end
    endtask

    task automatic reset_all();
        @(negedge clk);
        rst_d = 1'b0;
        rst_s = 1'b0;
        rst_f = 1'b0;
        repeat (3) @(negedge clk);
        rst_d = 1'b1;
        rst_s = 1'b1;
        rst_f = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_d = 1'b0; rst_s = 1'b0; rst_f = 1'b0;
        fs_d = 1'b0; fs_s = 1'b0; fs_f = 1'b0;
        en = 1'b1;
        reset_all();

        check("rst_ax", d_ax, 320);
        check("rst_ay", d_ay, 60);
        check("rst_bx", d_bx, 112);
        check("rst_by", d_by, 420);
        check("rst_cx", d_cx, 528);
        check("rst_cy", d_cy, 420);
        check("rst_mr", d_mr, 1);
        check("rst_md", d_md, VERT ? 1 : 0);
        check("rst_sp", d_sp, 0);

        frames(1, 3'b001);
        check("s1_ax", d_ax, 321);
        check("s1_bx", d_bx, 113);
        check("s1_cx", d_cx, 529);
        check("s1_sp", d_sp, 1);
        @(negedge clk);
        check("s1_sp_drop", d_sp, 0);
        check("s1_ax_hold", d_ax, 321);

        frames(110, 3'b001);
        check("edge_cx", d_cx, 639);
        check("edge_bx", d_bx, 223);
        check("edge_mr", d_mr, 0);
        frames(1, 3'b001);
        check("back_cx", d_cx, 638);
        check("back_bx", d_bx, 222);
        check("back_ax", d_ax, 430);

        en = 1'b0;
        frames(5, 3'b001);
        check("frz_cx", d_cx, 638);
        check("frz_sp", d_sp, 0);
        check("frz_mr", d_mr, 0);
        en = 1'b1;

        frames(221, 3'b001);
        check("left_bx1", d_bx, 1);
        check("left_mr0", d_mr, 0);
        frames(1, 3'b001);
        check("left_bx0", d_bx, 0);
        check("left_cx", d_cx, 416);
        check("left_ax", d_ax, 208);
        check("left_mr1", d_mr, 1);
        frames(1, 3'b001);
        check("right_bx", d_bx, 1);
        check("right_cx", d_cx, 417);

        frames(27, 3'b010);
        check("s4_cx27", s_cx, 636);
        check("s4_mr27", s_mr, 1);
        frames(1, 3'b010);
        check("s4_cx_clamp", s_cx, 639);
        check("s4_bx_clamp", s_bx, 223);
        check("s4_mr", s_mr, 0);
        frames(1, 3'b010);
        check("s4_cx_back", s_cx, 635);

        frames(2, 3'b100);
        check("f3_ax_2", f_ax, 320);
        check("f3_sp_2", f_sp, 0);
        frames(1, 3'b100);
        check("f3_ax_3", f_ax, 321);
        check("f3_sp_3", f_sp, 1);
        frames(2, 3'b100);
        check("f3_ax_5", f_ax, 321);
        rst_f = 1'b0;
        #1;
        check("f3_async_ax", f_ax, 320);
        check("f3_async_mr", f_mr, 1);
        @(negedge clk);
        rst_f = 1'b1;
        frames(2, 3'b100);
        check("f3_rst_ax_2", f_ax, 320);
        frames(1, 3'b100);
        check("f3_rst_ax_3", f_ax, 321);

        reset_all();
        frames(59, 3'b001);
        check("v59_ax", d_ax, 379);
        check("v59_ay", d_ay, VERT ? 119 : 60);
        check("v59_by", d_by, VERT ? 479 : 420);
        check("v59_cy", d_cy, VERT ? 479 : 420);
        check("v59_md", d_md, 0);
        frames(1, 3'b001);
        check("v60_ay", d_ay, VERT ? 118 : 60);
        check("v60_by", d_by, VERT ? 478 : 420);
        check("v60_md", d_md, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
